ifm_feeder: RTL and testbench
=============================

# ifm_feeder

- Streams one input-feature-map (IFM) tile from the IFM SRAM into the 4-entry IFM shift buffer, one signed byte per cycle, in raster order.
- Generates SRAM read addresses and absorbs the SRAM's 1-cycle read latency.
- Honours the shared pipeline `stall`.
- Drives the buffer's `ifm_input`/`ifm_read` pair, plus a window-valid flag for the PE array.

## Interface

Parameters:
- `DATA_W`, 8, IFM element width (signed).
- `IMG_W`, 16, tile width in elements (≥4).
- `IMG_H`, 16, tile height in rows (≥1).
- `ADDR_W`, 12, SRAM address width.
- `ROW_STRIDE`, 16, address increment between rows (≥`IMG_W`).

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `stall`  in  1  global pipeline freeze, shared with the shift buffer.
- `start`  in  1  one-cycle pulse; begin a tile. Ignored unless idle.
- `base_addr`  in  ADDR_W  tile origin; sampled on accepted `start`.
- `sram_rd_en`  out  1  SRAM read strobe.
- `sram_addr`  out  ADDR_W  SRAM read address.
- `sram_rdata`  in  DATA_W  read data, valid the cycle after `sram_rd_en`.
- `ifm_input`  out  DATA_W  element to the shift buffer (signed).
- `ifm_read`  out  1  shift strobe to the shift buffer.
- `win_valid`  out  1  with `ifm_read`: after this shift, the buffer holds 4 elements of the same row.
- `row_last`  out  1  with `ifm_read`: element is the last of its row.
- `busy`  out  1  tile in progress.
- `done`  out  1  one-cycle pulse after the last element is delivered.

## Operation

- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE → ISSUE on `start`. Latches `base_addr`; clears `row`/`col`.
  - ISSUE: one read per non-stalled cycle. Address = base + row·ROW_STRIDE + col.
    - `col` wraps at IMG_W-1, then `row` increments.
    - Moves to DRAIN after issuing (IMG_H-1, IMG_W-1).
  - DRAIN: waits until every in-flight element has been presented with `ifm_read`, and that cycle's edge is non-stalled. Then → DONE.
  - DONE: asserts `done` for one non-stalled cycle → IDLE.
- Address arithmetic:
  - Row base is accumulated by adding ROW_STRIDE; no multiplier.
  - Result wraps modulo 2^ADDR_W; no error flag.
- Output register: `ifm_input`/`ifm_read`/`win_valid`/`row_last` are registered.
  - `win_valid` = 1 when the element's column ≥3.
  - `row_last` = 1 when its column = IMG_W-1.
  - Column and last-tags travel with the data through the pipeline.
- `stall`=1 behaviour:
  - `sram_rd_en`=0.
  - FSM, counters and output register hold.
  - Return data from a read issued the previous cycle is captured into a 1-entry skid register.
  - After release, the skid drains into the output register before any new return data.
  - Issue resumes only when the skid is empty.
- `start` while busy: ignored. `start` coincident with `stall`: accepted.
- Reset (any time, including mid-tile):
  - All outputs 0, FSM to IDLE, skid and counters cleared.
  - No partial `done`.

## Timing

- `start` accepted at edge E: `sram_rd_en`=1 in cycle E+1.
- Read issued in cycle t: `ifm_read`=1 in cycle t+2. The buffer shifts at the end of t+2 if not stalled.
- Throughput with no stall: 1 element/cycle. Tile takes IMG_W·IMG_H + 3 cycles from `start` to `done`.
- `done` is high in the cycle after the last `ifm_read` cycle completes un-stalled.
- `busy` rises the cycle after `start` and falls with `done` deasserting.
- `ifm_read` remains asserted while stalled. The downstream buffer ignores it then; no element is lost or duplicated.
- Reset values: `sram_rd_en` 0, `sram_addr` 0, `ifm_input` 0, `ifm_read` 0, `win_valid` 0, `row_last` 0, `busy` 0, `done` 0.

## Structure

- Package `ifm_pkg`: DATA_W default, FSM state enum (IDLE/ISSUE/DRAIN/DONE), element-tag struct (data, win_valid, row_last).
- Sub-module `ifm_skid`: 1-entry skid register with valid flag, storing the tag struct; same clock/reset.
- Top contains FSM, row/col counters, address accumulator, in-flight flag and output register.

## Test plan

- IMG_W=4, IMG_H=2, base 0x100, SRAM[a]=a[7:0], no stall:
  - Addresses 0x100–0x103, then 0x110–0x113.
  - `ifm_read` 8 consecutive cycles, starting 2 after first issue.
  - `win_valid` only on elements 0x03 and 0x13; `row_last` on the same elements.
  - `done` at cycle 11.
- Same tile, `stall` high for 3 cycles starting the cycle after the second read:
  - Skid captures 0x01.
  - Element sequence after stall is identical; no gaps or duplicates in shifted bytes.
  - `done` delayed by exactly 3 cycles.
- Negative data (SRAM returns 0x80, 0xFF): `ifm_input` reproduces -128, -1 bit-exactly.
- `start` pulsed again mid-tile: ignored; address sequence and `done` count unchanged (one `done`).
- `rst_n` asserted mid-row-1: all outputs 0 asynchronously. A new `start` after release restarts at `base_addr` with correct first element.
- base 0xFFE, ADDR_W=12, IMG_W=4, IMG_H=1: addresses 0xFFE, 0xFFF, 0x000, 0x001 (wrap).

Source files
------------

// File: rtl/ifm_pkg.sv
// Shared types for the IFM feeder: element width, FSM states and the
// element tag that travels with each byte from SRAM to the shift buffer.
package ifm_pkg;

  localparam int IFM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ifm_state_e;

  // One element plus the window/row tags computed when its read was issued.
  typedef struct packed {
    logic signed [IFM_DATA_W-1:0] data;
    logic                         win_valid;
    logic                         row_last;
  } ifm_tag_t;

  localparam ifm_tag_t IFM_TAG_ZERO = ifm_tag_t'({(IFM_DATA_W + 2){1'b0}});

  // Bundle raw SRAM data with the tags that were issued alongside its read.
  function automatic ifm_tag_t ifm_make_tag(input logic [IFM_DATA_W-1:0] data,
                                            input logic                  win,
                                            input logic                  last);
    ifm_tag_t t;
    t.data      = $signed(data);
    t.win_valid = win;
    t.row_last  = last;
    return t;
  endfunction

endpackage

// File: rtl/ifm_skid.sv
// One-entry skid register. Catches the element returning from SRAM in a
// cycle where the pipeline is frozen, and hands it back on the next free edge.
module ifm_skid
  import ifm_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     capture,
  input  logic     drain,
  input  ifm_tag_t din,
  output logic     valid,
  output ifm_tag_t dout
);

  logic     valid_r;
  ifm_tag_t tag_r;

  // Park a returning element while frozen; empty out on the first unfrozen edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      tag_r   <= IFM_TAG_ZERO;
    end else if (capture) begin
      valid_r <= 1'b1;
      tag_r   <= din;
    end else if (drain) begin
      valid_r <= 1'b0;
    end
  end

  assign valid = valid_r;
  assign dout  = tag_r;

endmodule

// File: rtl/ifm_feeder.sv
// IFM feeder: walks one tile of the IFM SRAM in raster order, absorbs the
// one-cycle read latency and presents tagged bytes to the 4-entry shift
// buffer through a registered ifm_input/ifm_read pair. A shared stall
// freezes everything; an element returning during a freeze waits in the skid.
// DATA_W must match ifm_pkg::IFM_DATA_W, which sizes the element tag.
module ifm_feeder
  import ifm_pkg::*;
#(
  parameter int DATA_W     = IFM_DATA_W,
  parameter int IMG_W      = 16,
  parameter int IMG_H      = 16,
  parameter int ADDR_W     = 12,
  parameter int ROW_STRIDE = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     start,
  input  logic        [ADDR_W-1:0] base_addr,
  output logic                     sram_rd_en,
  output logic        [ADDR_W-1:0] sram_addr,
  input  logic        [DATA_W-1:0] sram_rdata,
  output logic signed [DATA_W-1:0] ifm_input,
  output logic                     ifm_read,
  output logic                     win_valid,
  output logic                     row_last,
  output logic                     busy,
  output logic                     done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0]  COL_WIN  = COL_W'(3);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ROW_STRIDE);

  ifm_state_e        state_r;
  logic [COL_W-1:0]  col_r;
  logic [ROW_W-1:0]  row_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] row_base_r;
  logic              busy_r;
  logic              done_r;

  logic              infl_r;
  logic              infl_win_r;
  logic              infl_last_r;

  logic              issue_s;
  logic              pending_s;
  ifm_tag_t          ret_tag_s;
  logic              skid_valid_s;
  ifm_tag_t          skid_tag_s;

  ifm_tag_t          out_tag_r;
  logic              out_read_r;

  // An unfrozen edge always moves a parked skid entry into the output
  // register, so a read issued in that same cycle returns to an empty skid
  // and the entry drains ahead of the new data.
  assign issue_s   = (state_r == ST_ISSUE) && !stall;
  assign pending_s = infl_r || skid_valid_s;
  assign ret_tag_s = ifm_make_tag(sram_rdata, infl_win_r, infl_last_r);

  // Tile sequencer: state, raster counters and the stride-accumulated address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      col_r      <= {COL_W{1'b0}};
      row_r      <= {ROW_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      row_base_r <= {ADDR_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_ISSUE;
            col_r      <= {COL_W{1'b0}};
            row_r      <= {ROW_W{1'b0}};
            addr_r     <= base_addr;
            row_base_r <= base_addr;
            busy_r     <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (issue_s) begin
            if (col_r == COL_LAST) begin
              col_r      <= {COL_W{1'b0}};
              row_base_r <= row_base_r + STRIDE;
              addr_r     <= row_base_r + STRIDE;
              if (row_r == ROW_LAST) begin
                state_r <= ST_DRAIN;
              end else begin
                row_r <= row_r + ROW_W'(1);
              end
            end else begin
              col_r  <= col_r + COL_W'(1);
              addr_r <= addr_r + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (!stall && !pending_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!stall) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Remember that a read is outstanding, with the tags of the column it came from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_r      <= 1'b0;
      infl_win_r  <= 1'b0;
      infl_last_r <= 1'b0;
    end else begin
      infl_r      <= issue_s;
      infl_win_r  <= issue_s && (col_r >= COL_WIN);
      infl_last_r <= issue_s && (col_r == COL_LAST);
    end
  end

  ifm_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (stall && infl_r),
    .drain   (!stall),
    .din     (ret_tag_s),
    .valid   (skid_valid_s),
    .dout    (skid_tag_s)
  );

  // Output register: the skid entry goes first, then fresh return data; frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_read_r <= 1'b0;
      out_tag_r  <= IFM_TAG_ZERO;
    end else if (!stall) begin
      if (skid_valid_s) begin
        out_read_r <= 1'b1;
        out_tag_r  <= skid_tag_s;
      end else if (infl_r) begin
        out_read_r <= 1'b1;
        out_tag_r  <= ret_tag_s;
      end else begin
        out_read_r <= 1'b0;
        out_tag_r  <= ifm_make_tag(out_tag_r.data, 1'b0, 1'b0);
      end
    end
  end

  assign sram_rd_en = issue_s;
  assign sram_addr  = addr_r;
  assign ifm_input  = out_tag_r.data;
  assign ifm_read   = out_read_r;
  assign win_valid  = out_tag_r.win_valid;
  assign row_last   = out_tag_r.row_last;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_ifm_feeder.sv
// Bench for ifm_feeder on a 4x2 tile with row stride 16. A behavioural
// SRAM answers reads one cycle later; the expected address stream and
// element stream are computed directly from the raster walk of the tile.
module tb_ifm_feeder;

  localparam int W      = 4;
  localparam int H      = 2;
  localparam int STRIDE = 16;
  localparam int N      = W * H;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               stall;
  logic               start;
  logic [11:0]        base_addr;
  logic               sram_rd_en;
  logic [11:0]        sram_addr;
  logic [7:0]         sram_rdata;
  logic signed [7:0]  ifm_input;
  logic               ifm_read;
  logic               win_valid;
  logic               row_last;
  logic               busy;
  logic               done;

  logic [7:0] mem [0:4095];

  typedef struct packed {
    logic signed [7:0] data;
    logic              win;
    logic              last;
  } el_t;

  typedef struct {
    logic [11:0] base;
    int          stall_at;
    int          stall_len;
    int          restart_at;
    bit          neg;
    int          exp_done;
  } vec_t;

  int  checks   = 0;
  int  failures = 0;
  el_t last_els[$];

  always #5 clk = ~clk;

  ifm_feeder #(
    .DATA_W     (8),
    .IMG_W      (W),
    .IMG_H      (H),
    .ADDR_W     (12),
    .ROW_STRIDE (STRIDE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .start      (start),
    .base_addr  (base_addr),
    .sram_rd_en (sram_rd_en),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .ifm_input  (ifm_input),
    .ifm_read   (ifm_read),
    .win_valid  (win_valid),
    .row_last   (row_last),
    .busy       (busy),
    .done       (done)
  );

  // SRAM with one-cycle read latency; junk on the bus when not reading.
  always @(posedge clk) begin
    if (sram_rd_en) sram_rdata <= mem[sram_addr];
    else            sram_rdata <= 8'($urandom);
  end

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fill_mem(input bit rnd);
    for (int a = 0; a < 4096; a++) mem[a] = rnd ? 8'($urandom) : 8'(a);
  endtask

  // Runs one tile from start to the cycle after done and compares against the raster model.
  task automatic run_tile(input logic [11:0] base, input int stall_at, input int stall_len,
                          input bit rnd, input int restart_at, input int exp_done, input string tag);
    logic [11:0] exp_addr[$];
    el_t         exp_el[$];
    logic [11:0] got_addr[$];
    el_t         got_el[$];
    logic [11:0] a;
    el_t         e;
    int          cyc, first_rd, first_read, done_first, done_end, done_pulses, stall_cnt, busy_bad;
    logic        busy_exp;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        a = base + 12'(r * STRIDE + c);
        exp_addr.push_back(a);
        e.data = mem[a];
        e.win  = (c >= 3);
        e.last = (c == W - 1);
        exp_el.push_back(e);
      end
    end
    first_rd = -1; first_read = -1; done_first = -1; done_end = -1;
    done_pulses = 0; stall_cnt = 0; busy_bad = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = base;
    stall     = rnd ? ($urandom_range(0, 99) < 30) : (stall_at <= 0 && stall_at + stall_len > 0);
    cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      if (done && done_first < 0) done_first = cyc;
      if (done_first < 0 && cyc >= 1 && stall) stall_cnt++;
      if (sram_rd_en) begin
        got_addr.push_back(sram_addr);
        if (first_rd < 0) first_rd = cyc;
      end
      if (ifm_read && first_read < 0) first_read = cyc;
      if (ifm_read && !stall) begin
        e.data = ifm_input; e.win = win_valid; e.last = row_last;
        got_el.push_back(e);
      end
      if (done && !stall) begin
        done_pulses++;
        if (done_end < 0) done_end = cyc;
      end
      busy_exp = (cyc >= 1) && (done_end < 0 || cyc <= done_end);
      if (busy !== busy_exp) busy_bad++;
      if (done_end >= 0 && cyc == done_end + 1) break;
      @(posedge clk); #1;
      cyc++;
      start     = (cyc == restart_at);
      base_addr = (cyc == restart_at) ? (base ^ 12'h0A0) : base;
      stall     = rnd ? (done_end < 0 && $urandom_range(0, 99) < 30)
                      : (cyc >= stall_at && cyc < stall_at + stall_len);
    end
    start = 1'b0;
    stall = 1'b0;
    chk({tag, "_done_seen"}, (done_end >= 0), 1);
    chk({tag, "_addr_cnt"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
    chk({tag, "_elem_cnt"}, got_el.size(), exp_el.size());
    for (int i = 0; i < exp_el.size() && i < got_el.size(); i++)
      chk($sformatf("%s_elem%0d", tag, i), got_el[i], exp_el[i]);
    chk({tag, "_done_pulses"}, done_pulses, 1);
    chk({tag, "_done_cycle"}, done_first, (exp_done >= 0) ? exp_done : (N + 3 + stall_cnt));
    chk({tag, "_busy"}, busy_bad, 0);
    if (!rnd && stall_len == 0) begin
      chk({tag, "_first_rd"}, first_rd, 1);
      chk({tag, "_first_ifm_read"}, first_read, 3);
    end
    last_els = got_el;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    logic [11:0] rb;
    vt[0] = '{base: 12'h100, stall_at: -10, stall_len: 0, restart_at: -1, neg: 1'b0, exp_done: 11};
    vt[1] = '{base: 12'h100, stall_at: 3,   stall_len: 3, restart_at: -1, neg: 1'b0, exp_done: 14};
    vt[2] = '{base: 12'h200, stall_at: -10, stall_len: 0, restart_at: -1, neg: 1'b1, exp_done: 11};
    vt[3] = '{base: 12'h100, stall_at: -10, stall_len: 0, restart_at: 5,  neg: 1'b0, exp_done: 11};
    vt[4] = '{base: 12'hFFE, stall_at: -10, stall_len: 0, restart_at: -1, neg: 1'b0, exp_done: 11};
    vt[5] = '{base: 12'h0F0, stall_at: 9,   stall_len: 2, restart_at: -1, neg: 1'b0, exp_done: 13};
    vt[6] = '{base: 12'h300, stall_at: 1,   stall_len: 1, restart_at: -1, neg: 1'b0, exp_done: 12};

    rst_n = 1'b0; stall = 1'b0; start = 1'b0; base_addr = 12'h000;
    fill_mem(1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs", {sram_rd_en, sram_addr, ifm_input, ifm_read, win_valid, row_last, busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_outputs", {sram_rd_en, sram_addr, ifm_input, ifm_read, win_valid, row_last, busy, done}, 0);

    for (int v = 0; v < 7; v++) begin
      fill_mem(1'b0);
      if (vt[v].neg) begin
        mem[vt[v].base]          = 8'h80;
        mem[vt[v].base + 12'd1]  = 8'hFF;
      end
      run_tile(vt[v].base, vt[v].stall_at, vt[v].stall_len, 1'b0, vt[v].restart_at,
               vt[v].exp_done, $sformatf("vec%0d", v));
      if (vt[v].neg && last_els.size() >= 2) begin
        chk("neg_first", int'(last_els[0].data), -128);
        chk("neg_second", int'(last_els[1].data), -1);
      end
    end

    // Reset in the middle of row 1, then a clean restart.
    fill_mem(1'b0);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'h100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("pre_rst_addr", sram_addr, 12'h111);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {sram_rd_en, sram_addr, ifm_input, ifm_read, win_valid, row_last, busy, done}, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_hold_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_tile(12'h100, -10, 0, 1'b0, -1, 11, "after_rst");

    // Randomized tiles: random base, random data, random stall pattern.
    for (int k = 0; k < 12; k++) begin
      fill_mem(1'b1);
      rb = 12'($urandom_range(0, 4095));
      run_tile(rb, -10, 0, 1'b1, -1, -1, $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
